// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - writeback pipeline register with optional two-entry skid buffer (WB_PIPE_SKID_EN)
module wb_pipe_stage #(
    parameter int IDX_W  = 5,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              in_wr_en,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_wr_en,
    output logic [SEL_W-1:0]  out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid, m_valid_n;
    logic [IDX_W-1:0]  m_index, m_index_n;
    logic              m_wr_en, m_wr_en_n;
    logic [SEL_W-1:0]  m_sel, m_sel_n;
    logic [DATA_W-1:0] m_data, m_data_n;

    logic accept;
    logic pop;

    assign pop    = m_valid & out_ready;
    assign accept = in_valid & in_ready;

`ifdef WB_PIPE_SKID_EN
    logic              s_valid, s_valid_n;
    logic [IDX_W-1:0]  s_index, s_index_n;
    logic              s_wr_en, s_wr_en_n;
    logic [SEL_W-1:0]  s_sel, s_sel_n;
    logic [DATA_W-1:0] s_data, s_data_n;
    logic              ready_q;

    // in_ready is registered from the next skid state, so it never sees in_* or out_ready combinationally
    assign in_ready = ready_q;

    always_comb begin
        m_valid_n = m_valid;
        m_index_n = m_index;
        m_wr_en_n = m_wr_en;
        m_sel_n   = m_sel;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_index_n = s_index;
        s_wr_en_n = s_wr_en;
        s_sel_n   = s_sel;
        s_data_n  = s_data;
        if (!m_valid || pop) begin
            if (s_valid) begin
                m_valid_n = 1'b1;
                m_index_n = s_index;
                m_wr_en_n = s_wr_en;
                m_sel_n   = s_sel;
                m_data_n  = s_data;
                s_valid_n = 1'b0;
                s_index_n = '0;
                s_wr_en_n = 1'b0;
                s_sel_n   = '0;
                s_data_n  = '0;
            end else if (accept) begin
                m_valid_n = 1'b1;
                m_index_n = in_index;
                m_wr_en_n = in_wr_en;
                m_sel_n   = in_sel;
                m_data_n  = in_data;
            end else begin
                m_valid_n = 1'b0;
                m_index_n = '0;
                m_wr_en_n = 1'b0;
                m_sel_n   = '0;
                m_data_n  = '0;
            end
        end else if (accept) begin
            s_valid_n = 1'b1;
            s_index_n = in_index;
            s_wr_en_n = in_wr_en;
            s_sel_n   = in_sel;
            s_data_n  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s_valid <= 1'b0;
            s_index <= '0;
            s_wr_en <= 1'b0;
            s_sel   <= '0;
            s_data  <= '0;
            ready_q <= 1'b1;
        end else begin
            s_valid <= s_valid_n;
            s_index <= s_index_n;
            s_wr_en <= s_wr_en_n;
            s_sel   <= s_sel_n;
            s_data  <= s_data_n;
            ready_q <= !s_valid_n;
        end
    end

    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
    // Single-entry build: space frees up in the same cycle the head is consumed
    assign in_ready = !m_valid | out_ready;

    always_comb begin
        m_valid_n = m_valid;
        m_index_n = m_index;
        m_wr_en_n = m_wr_en;
        m_sel_n   = m_sel;
        m_data_n  = m_data;
        if (!m_valid || pop) begin
            if (accept) begin
                m_valid_n = 1'b1;
                m_index_n = in_index;
                m_wr_en_n = in_wr_en;
                m_sel_n   = in_sel;
                m_data_n  = in_data;
            end else begin
                m_valid_n = 1'b0;
                m_index_n = '0;
                m_wr_en_n = 1'b0;
                m_sel_n   = '0;
                m_data_n  = '0;
            end
        end
    end

    assign occupancy = {1'b0, m_valid};
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid <= 1'b0;
            m_index <= '0;
            m_wr_en <= 1'b0;
            m_sel   <= '0;
            m_data  <= '0;
        end else begin
            m_valid <= m_valid_n;
            m_index <= m_index_n;
            m_wr_en <= m_wr_en_n;
            m_sel   <= m_sel_n;
            m_data  <= m_data_n;
        end
    end

    // A bubble must never write the register file
    assign out_valid = m_valid;
    assign out_wr_en = m_wr_en & m_valid;
    assign out_index = m_index;
    assign out_sel   = m_sel;
    assign out_data  = m_data;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - self-checking bench for wb_pipe_stage against a queue model
module tb_wb_pipe_stage;

    localparam int IDX_W  = 5;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;
`ifdef WB_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  in_index = '0;
    logic              in_wr_en = 1'b0;
    logic [SEL_W-1:0]  in_sel = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_index;
    logic              out_wr_en;
    logic [SEL_W-1:0]  out_sel;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    wb_pipe_stage #(.IDX_W(IDX_W), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
        .in_wr_en(in_wr_en), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_wr_en(out_wr_en), .out_sel(out_sel), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  index;
        logic              wr_en;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t q[$];
    bit     clean = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, then advance the model
    task automatic step(input bit iv, input int idx, input bit we, input int sel, input int data,
                        input bit ordy, input bit fl, input bit rs, input bit chk);
        bit     exp_rdy;
        entry_t e;
        @(negedge clk);
        in_valid  = iv;
        in_index  = idx[IDX_W-1:0];
        in_wr_en  = we;
        in_sel    = sel[SEL_W-1:0];
        in_data   = data[DATA_W-1:0];
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        if (CAP == 2) exp_rdy = (q.size() < 2);
        else          exp_rdy = (q.size() == 0) || ordy;
        if (chk) begin
            check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            check("occupancy", {62'd0, occupancy}, 64'(q.size()));
            check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("out_index", 64'(out_index), 64'(q[0].index));
                check("out_wr_en", {63'd0, out_wr_en}, {63'd0, q[0].wr_en});
                check("out_sel", 64'(out_sel), 64'(q[0].sel));
                check("out_data", 64'(out_data), 64'(q[0].data));
            end else begin
                check("bubble_wr_en", {63'd0, out_wr_en}, 64'd0);
                if (clean) begin
                    check("empty_index", 64'(out_index), 64'd0);
                    check("empty_sel", 64'(out_sel), 64'd0);
                    check("empty_data", 64'(out_data), 64'd0);
                end
            end
        end
        if (rs || fl) begin
            q.delete();
            clean = 1'b1;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && exp_rdy) begin
                e.index = idx[IDX_W-1:0];
                e.wr_en = we;
                e.sel   = sel[SEL_W-1:0];
                e.data  = data[DATA_W-1:0];
                q.push_back(e);
                clean = 1'b0;
            end
        end
    endtask

    initial begin
        step(1, 4, 1, 1, 99, 0, 0, 1, 0);
        step(1, 4, 1, 1, 99, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 1; i <= 8; i++) step(1, i, 1, 1, i * 4, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);

        step(1, 3, 1, 2, 33, 0, 0, 0, 1);
        step(1, 7, 1, 3, 77, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);

        step(1, 3, 1, 0, 5, 0, 0, 0, 1);
        step(1, 7, 0, 1, 6, 0, 0, 0, 1);
        step(1, 9, 1, 2, 9, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 5; i++) step(0, 21, 1, 3, 123, 1, 0, 0, 1);

        step(1, 5, 1, 1, 55, 0, 0, 0, 1);
        step(1, 6, 1, 2, 66, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0, 1);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised writeback-stage pipeline register for the pipelined RISC-V core, sitting between MEM and the register-file write port. It carries register write index, write enable, writeback data-select and a generic payload through a valid/ready handshake. It adds back-pressure (stall), flush and a two-entry skid buffer so upstream ready never depends combinationally on downstream ready.

## Interface
Parameters:
- IDX_W, 5, register write-index width
- SEL_W, 2, writeback data-select width
- DATA_W, 32, payload width (result/load data)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous kill of all held entries (branch/trap)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts entry this cycle
- in_index  in  IDX_W  write index
- in_wr_en  in  1  register write enable
- in_sel  in  SEL_W  data-select
- in_data  in  DATA_W  payload
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes head this cycle
- out_index  out  IDX_W  head write index
- out_wr_en  out  1  head write enable, qualified: stored wr_en AND out_valid
- out_sel  out  SEL_W  head data-select
- out_data  out  DATA_W  head payload
- occupancy  out  2  entries held (0..2)

## Operation
- Storage: main entry (drives outputs) and skid entry, each {valid, index, wr_en, sel, data}.
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready is a register: 1 exactly when skid entry is empty.
- Per cycle, with main M and skid S:
  - M empty: accepted entry loads M.
  - M full, pop, S empty: accepted entry loads M; no accept → M empties.
  - M full, pop, S full: S moves to M, S empties (no accept possible, in_ready=0).
  - M full, no pop, accept: entry loads S; in_ready drops next cycle.
  - M full, no pop, no accept: hold.
- Simultaneous accept and pop with S empty: occupancy stays 1, M takes new entry; order strictly FIFO.
- flush: clears both valid bits; an entry presented on in_* that cycle is dropped, regardless of in_ready. Pop in the flush cycle still completes downstream (head visible during that cycle).
- rst has priority over flush; both yield the same empty state.
- out_wr_en is never 1 while out_valid=0, so a bubble never writes the register file.
- occupancy = M.valid + S.valid.

## Timing
- Reset values (cycle after rst sampled high): out_valid=0, out_wr_en=0, out_index=0, out_sel=0, out_data=0, occupancy=0, in_ready=1. Payload fields in empty slots read 0 after reset/flush, never X.
- Latency: entry accepted at edge N is on out_* after edge N (available cycle N+1); pass-through throughput 1 entry/cycle with out_ready held high.
- in_ready deasserts the cycle after S fills; reasserts the cycle after S drains.
- No combinational path in_* or out_ready → in_ready; out_ready → out_* also registered.
- Reset or flush mid-stall discards both entries; no partial output.

## Configuration
- WB_PIPE_SKID_EN defined: two-entry skid behaviour above; occupancy range 0..2.
- Undefined: S omitted; single entry; in_ready = !out_valid | out_ready (combinational); occupancy range 0..1, bit 1 tied 0. Flush/rst/qualified out_wr_en identical.

## Test plan
- Reset: rst high 2 cycles with in_valid=1 → out_valid=0, out_wr_en=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, entries idx 1..8, wr_en=1, sel=2'b01, data=idx*4 → same sequence one cycle later, one per cycle, occupancy stays 1.
- Stall fill: out_ready=0, send idx 3 then idx 7 → occupancy=2, in_ready=0 next cycle; release out_ready → out idx 3 then 7, in_ready back to 1.
- Flush: occupancy=2, flush with in_valid=1 idx 9 → next cycle out_valid=0, occupancy=0, idx 9 never appears.
- Bubble safety: in_valid=0 with in_wr_en=1 for 5 cycles → out_wr_en stays 0.
- Macro off: out_ready=0, send idx 5 → in_ready=0 same cycle as out_valid=1; out_ready=1 with new idx 6 → 6 replaces 5 in one cycle.
